// File: rtl/best_match_sel_pkg.sv
// rtl/best_match_sel_pkg.sv - shared score format, threshold default and state encoding
package best_match_sel_pkg;

  localparam int FRAC_W      = 8;
  localparam int PIX_W       = 8;
  localparam int SCORE_W_DEF = PIX_W + 13;
  localparam int THRESH_DEF  = 1 << FRAC_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/best_match_sel_pos_counter.sv
// rtl/best_match_sel_pos_counter.sv - raster x/y position tracker with sticky overflow
module pos_counter #(
  parameter int COLS = 640,
  parameter int ROWS = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    adv,
  output logic [$clog2(COLS)-1:0] x_nxt,
  output logic [$clog2(ROWS)-1:0] y_nxt,
  output logic                    ovf_nxt
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          ovf;

  // Position the next non-sof sample would occupy; the top compares against it in the same cycle.
  always_comb begin
    x_nxt   = x + XW'(1);
    y_nxt   = y;
    ovf_nxt = ovf;
    if (x == XW'(COLS - 1)) begin
      x_nxt = '0;
      if (y == YW'(ROWS - 1)) begin
        y_nxt   = '0;
        ovf_nxt = 1'b1;
      end else begin
        y_nxt = y + YW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x   <= '0;
      y   <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      x   <= '0;
      y   <= '0;
      ovf <= 1'b0;
    end else if (adv) begin
      x   <= x_nxt;
      y   <= y_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: rtl/best_match_sel.sv
// rtl/best_match_sel.sv - per-frame best score and position selector
module best_match_sel
  import best_match_sel_pkg::*;
#(
  parameter int WIDTH   = PIX_W,
  parameter int SCORE_W = WIDTH + (SCORE_W_DEF - PIX_W),
  parameter int COLS    = 640,
  parameter int ROWS    = 480,
  parameter int THRESH  = THRESH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SCORE_W-1:0]      score,
  input  logic                    score_vld,
  input  logic                    sof,
  input  logic                    eof,
  output logic [SCORE_W-1:0]      best_score,
  output logic [$clog2(COLS)-1:0] best_x,
  output logic [$clog2(ROWS)-1:0] best_y,
  output logic                    found,
  output logic                    err,
  output logic                    done
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  state_t        state;
  logic [SCORE_W-1:0] run_max;
  logic [XW-1:0] run_x;
  logic [YW-1:0] run_y;
  logic [XW-1:0] smp_x;
  logic [YW-1:0] smp_y;
  logic          ovf_nxt;
  logic          start;
  logic          adv;
  logic          take;
  logic [SCORE_W-1:0] win_score;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;

  assign start = score_vld & sof;
  assign adv   = score_vld & ~sof & (state == ST_ACCUM);

  pos_counter #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .adv     (adv),
    .x_nxt   (smp_x),
    .y_nxt   (smp_y),
    .ovf_nxt (ovf_nxt)
  );

  // Strict compare keeps the earliest position on ties.
  assign take = score > run_max;

  always_comb begin
    win_score = run_max;
    win_x     = run_x;
    win_y     = run_y;
    if (take) begin
      win_score = score;
      win_x     = smp_x;
      win_y     = smp_y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      run_max    <= '0;
      run_x      <= '0;
      run_y      <= '0;
      best_score <= '0;
      best_x     <= '0;
      best_y     <= '0;
      found      <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run_max <= score;
        run_x   <= '0;
        run_y   <= '0;
        state   <= ST_ACCUM;
        if (eof) begin
          best_score <= score;
          best_x     <= '0;
          best_y     <= '0;
          found      <= (score >= SCORE_W'(THRESH));
          err        <= 1'b0;
          done       <= 1'b1;
          state      <= ST_IDLE;
        end
      end else if (adv) begin
        run_max <= win_score;
        run_x   <= win_x;
        run_y   <= win_y;
        if (eof) begin
          best_score <= win_score;
          best_x     <= win_x;
          best_y     <= win_y;
          found      <= (win_score >= SCORE_W'(THRESH));
          err        <= ovf_nxt;
          done       <= 1'b1;
          state      <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: doc/best_match_sel.md
BEST_MATCH_SEL -- requirements
Module: best_match_sel

Interface
REQ-001 Parameter WIDTH, default 8: pixel value width used by the upstream score stage.
REQ-002 Parameter SCORE_W, default WIDTH+13: score width, 21 bits at default; integer part above bit 8, 8 fractional bits.
REQ-003 Parameter COLS, default 640: candidate positions per row.
REQ-004 Parameter ROWS, default 480: candidate rows per frame.
REQ-005 Parameter THRESH, default 256 (1.0 in 8-bit fraction): minimum score counted as a match.
REQ-006 clk  input  1  single clock; all logic is on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 score  input  SCORE_W  score of the current candidate position from the upstream score stage.
REQ-009 score_vld  input  1  score is valid this cycle; already aligned to the upstream pipeline latency.
REQ-010 sof  input  1  first candidate of a frame; qualified by score_vld.
REQ-011 eof  input  1  last candidate of a frame; qualified by score_vld.
REQ-012 best_score  output  SCORE_W  highest score of the last completed frame.
REQ-013 best_x  output  clog2(COLS)  column of best_score.
REQ-014 best_y  output  clog2(ROWS)  row of best_score.
REQ-015 found  output  1  best_score >= THRESH.
REQ-016 err  output  1  last completed frame held more than COLS*ROWS samples.
REQ-017 done  output  1  one-cycle pulse: result outputs were updated.

Function
REQ-018 Two states: IDLE and ACCUM.
REQ-019 IDLE ignores all samples until score_vld&sof.
REQ-020 score_vld&sof, in either state, goes to ACCUM and sets x=0, y=0, sample count=1, running max=score, running position=(0,0), overflow=0.
REQ-021 In ACCUM, score_vld without sof advances x by 1; at x=COLS-1, x wraps to 0 and y advances by 1; at y=ROWS-1 with x=COLS-1, both wrap to 0 and overflow becomes sticky 1.
REQ-022 Running max updates only when score > running max (strict, unsigned), so on ties the earliest position wins.
REQ-023 score_vld&eof (ACCUM, or together with sof) compares that final sample, then loads best_score/best_x/best_y/found/err on the next edge, pulses done for exactly one cycle, and returns to IDLE.
REQ-024 sof and eof in the same valid cycle form a one-sample frame: result = that score at (0,0).
REQ-025 sof or eof with score_vld=0 has no effect.
REQ-026 A sof arriving in ACCUM before eof discards the partial frame without pulsing done.
REQ-027 Result outputs hold their values between done pulses.
REQ-028 Latency from the eof sample to done and valid results is 1 clock.
REQ-029 The block accepts one sample per cycle with no back-pressure.

Reset
REQ-030 rst low asynchronously clears state to IDLE and clears all counters, the running max, and every output (including done) to 0.
REQ-031 Reset asserted mid-frame discards that frame, and no done is produced for it.

Structure
REQ-032 SCORE_W, the fractional-bit count (8), THRESH default, and the state encoding belong in a shared package used with the score stage.
REQ-033 One sub-module, pos_counter, owns x/y wrap and the overflow flag; the remaining compare/state logic lives in best_match_sel.

Verification (COLS=4, ROWS=3, THRESH=256)
REQ-034 12 valid samples with score=index, except index 6 = 500, sof on index 0, eof on index 11 -> done 1 cycle after index 11; best_score=500, x=2, y=1, found=1, err=0.
REQ-035 Score 100 at indices 3 and 9, all others 10 -> best_score=100, x=3, y=0, found=0.
REQ-036 5 samples (max 900), then new sof with scores 7,1,2 and eof -> exactly one done; best_score=7, x=0, y=0.
REQ-037 Single valid cycle with sof=eof=1, score=42 -> done next cycle, best_score=42, (0,0); samples before any sof produce nothing.
REQ-038 rst pulsed low mid-frame, then 12-sample frame plus one extra sample before eof -> outputs 0 during reset, no done for the aborted frame; next done has err=1.
